unidade_controle: RTL and testbench

//   Multicycle control FSM for processador_multiciclo: latches a 9-bit instruction from DIN when Run is

---
 rtl/proc_pkg.sv | 27 ++
 rtl/dec3to8.sv | 13 +
 rtl/unidade_controle.sv | 113 +++++++++++
 tb/tb_unidade_controle.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared constants for the multicycle processor control path:
// opcodes, instruction field positions and the T-step state type.
package proc_pkg;

  localparam int NUM_REGS = 8;
  localparam int IR_WIDTH = 9;

  localparam logic [2:0] OPC_MV  = 3'b000;
  localparam logic [2:0] OPC_MVI = 3'b001;
  localparam logic [2:0] OPC_ADD = 3'b010;
  localparam logic [2:0] OPC_SUB = 3'b011;

  localparam int III_MSB = 8;
  localparam int III_LSB = 6;
  localparam int XXX_MSB = 5;
  localparam int XXX_LSB = 3;
  localparam int YYY_MSB = 2;
  localparam int YYY_LSB = 0;

  typedef enum logic [1:0] {
    T0 = 2'b00,
    T1 = 2'b01,
    T2 = 2'b10,
    T3 = 2'b11
  } tstep_t;

endpackage

// File: rtl/dec3to8.sv
// 3-bit binary to 8-bit one-hot decoder; all outputs low when disabled.
module dec3to8 (
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/unidade_controle.sv
// Multicycle control FSM: owns the IR, steps T0..T3 and decodes the
// datapath strobes from the current step and the latched instruction.
module unidade_controle
  import proc_pkg::*;
(
  input  logic                Clock,
  input  logic                Resetn,
  input  logic                Run,
  input  logic [15:0]         DIN,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic                DINout,
  output logic                Gout,
  output logic                Ain,
  output logic                Gin,
  output logic                AddSub,
  output logic                Done,
  output logic [1:0]          Tstep
);

  tstep_t              state;
  logic [IR_WIDTH-1:0] ir;
  logic [2:0]          opc;
  logic [2:0]          rx;
  logic [2:0]          ry;
  logic                is_alu;
  logic                rin_en;
  logic                rout_en;
  logic                rout_sel_x;
  logic [2:0]          rout_sel;
  logic                unused_din;

  assign opc        = ir[III_MSB:III_LSB];
  assign rx         = ir[XXX_MSB:XXX_LSB];
  assign ry         = ir[YYY_MSB:YYY_LSB];
  assign is_alu     = (opc == OPC_ADD) || (opc == OPC_SUB);
  assign rout_sel   = rout_sel_x ? rx : ry;
  assign Tstep      = state;
  assign unused_din = ^DIN[15:IR_WIDTH];

  // Run is only looked at in T0, so the IR cannot change mid-instruction
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= T0;
      ir    <= '0;
    end else begin
      case (state)
        T0: if (Run) begin
          ir    <= DIN[IR_WIDTH-1:0];
          state <= T1;
        end
        T1:      state <= is_alu ? T2 : T0;
        T2:      state <= T3;
        default: state <= T0;
      endcase
    end
  end

  always_comb begin
    rin_en     = 1'b0;
    rout_en    = 1'b0;
    rout_sel_x = 1'b0;
    DINout     = 1'b0;
    Gout       = 1'b0;
    Ain        = 1'b0;
    Gin        = 1'b0;
    AddSub     = 1'b0;
    Done       = 1'b0;
    case (state)
      T1: begin
        if (opc == OPC_MV) begin
          rout_en = 1'b1;
          rin_en  = 1'b1;
          Done    = 1'b1;
        end else if (opc == OPC_MVI) begin
          DINout = 1'b1;
          rin_en = 1'b1;
          Done   = 1'b1;
        end else if (is_alu) begin
          rout_en    = 1'b1;
          rout_sel_x = 1'b1;
          Ain        = 1'b1;
        end else begin
          Done = 1'b1;
        end
      end
      T2: begin
        rout_en = 1'b1;
        Gin     = 1'b1;
        AddSub  = (opc == OPC_SUB);
      end
      T3: begin
        Gout   = 1'b1;
        rin_en = 1'b1;
        Done   = 1'b1;
      end
      default: ;
    endcase
  end

  dec3to8 u_dec_rin (
    .en     (rin_en),
    .sel    (rx),
    .onehot (Rin)
  );

  dec3to8 u_dec_rout (
    .en     (rout_en),
    .sel    (rout_sel),
    .onehot (Rout)
  );

endmodule

// File: tb/tb_unidade_controle.sv
// Randomized self-checking bench for unidade_controle against a per-instruction
// table of expected strobes built from the instruction set rules.
module tb_unidade_controle;

  typedef struct packed {
    logic [7:0] rin;
    logic [7:0] rout;
    logic       dinout;
    logic       gout;
    logic       ain;
    logic       gin;
    logic       addsub;
    logic       done;
    logic [1:0] tstep;
  } ctl_t;

  logic        Clock;
  logic        Resetn;
  logic        Run;
  logic [15:0] DIN;
  logic [7:0]  Rin;
  logic [7:0]  Rout;
  logic        DINout;
  logic        Gout;
  logic        Ain;
  logic        Gin;
  logic        AddSub;
  logic        Done;
  logic [1:0]  Tstep;

  int vectors;
  int miscompares;

  unidade_controle dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Run    (Run),
    .DIN    (DIN),
    .Rin    (Rin),
    .Rout   (Rout),
    .DINout (DINout),
    .Gout   (Gout),
    .Ain    (Ain),
    .Gin    (Gin),
    .AddSub (AddSub),
    .Done   (Done),
    .Tstep  (Tstep)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic ctl_t observed();
    ctl_t o;
    o = '{rin: Rin, rout: Rout, dinout: DINout, gout: Gout, ain: Ain,
          gin: Gin, addsub: AddSub, done: Done, tstep: Tstep};
    return o;
  endfunction

  // Expected control word for step k (0 = T1) of an instruction
  function automatic ctl_t model(logic [8:0] ir, int k);
    ctl_t       e;
    logic [2:0] op;
    logic [2:0] x;
    logic [2:0] y;
    op = ir[8:6];
    x  = ir[5:3];
    y  = ir[2:0];
    e  = '0;
    e.tstep = 2'(k + 1);
    if (op == 3'd0) begin
      e.rout = 8'b1 << y;
      e.rin  = 8'b1 << x;
      e.done = 1'b1;
    end else if (op == 3'd1) begin
      e.dinout = 1'b1;
      e.rin    = 8'b1 << x;
      e.done   = 1'b1;
    end else if (op == 3'd2 || op == 3'd3) begin
      if (k == 0) begin
        e.rout = 8'b1 << x;
        e.ain  = 1'b1;
      end else if (k == 1) begin
        e.rout   = 8'b1 << y;
        e.gin    = 1'b1;
        e.addsub = (op == 3'd3);
      end else begin
        e.gout = 1'b1;
        e.rin  = 8'b1 << x;
        e.done = 1'b1;
      end
    end else begin
      e.done = 1'b1;
    end
    return e;
  endfunction

  function automatic int steps(logic [8:0] ir);
    return (ir[8:6] == 3'd2 || ir[8:6] == 3'd3) ? 3 : 1;
  endfunction

  task automatic checkOutput(input string tag, input ctl_t got, input ctl_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge while in T0; leaves the bench at the next T0 falling edge
  task automatic applyStimulus(input logic [8:0] ir, input bit hold_run);
    checkOutput("t0_idle", observed(), ctl_t'('0));
    Run = 1'b1;
    DIN = {7'($urandom), ir};
    for (int k = 0; k < steps(ir); k++) begin
      @(negedge Clock);
      checkOutput($sformatf("ir%03h_k%0d", ir, k), observed(), model(ir, k));
      Run = hold_run ? 1'b1 : 1'($urandom);
      DIN = 16'($urandom);
    end
    @(negedge Clock);
  endtask

  task automatic idleCycle();
    checkOutput("t0_wait", observed(), ctl_t'('0));
    Run = 1'b0;
    DIN = 16'($urandom);
    @(negedge Clock);
    checkOutput("t0_hold", observed(), ctl_t'('0));
  endtask

  initial begin
    ctl_t t1_exp;
    vectors     = 0;
    miscompares = 0;
    Resetn = 1'b1;
    Run    = 1'b0;
    DIN    = '0;
    #2 Resetn = 1'b0;
    #1 checkOutput("reset_async", observed(), ctl_t'('0));
    @(negedge Clock);
    checkOutput("reset_held", observed(), ctl_t'('0));
    @(negedge Clock);
    Resetn = 1'b1;

    applyStimulus(9'b001_000_000, 1'b0);
    applyStimulus(9'b000_010_101, 1'b0);
    applyStimulus(9'b011_001_110, 1'b0);
    applyStimulus(9'b110_000_000, 1'b0);
    applyStimulus(9'b010_011_011, 1'b0);
    applyStimulus(9'b010_100_111, 1'b1);
    applyStimulus(9'b000_111_001, 1'b1);
    idleCycle();

    // Reset asserted in the middle of T2 of an add
    checkOutput("t0_pre_rst", observed(), ctl_t'('0));
    Run = 1'b1;
    DIN = 16'h00A1;
    @(negedge Clock);
    Run = 1'b0;
    t1_exp = model(9'h0A1, 0);
    checkOutput("rst_add_t1", observed(), t1_exp);
    @(negedge Clock);
    checkOutput("rst_add_t2", observed(), model(9'h0A1, 1));
    #2 Resetn = 1'b0;
    #1 checkOutput("rst_mid_async", observed(), ctl_t'('0));
    @(negedge Clock);
    checkOutput("rst_mid_held", observed(), ctl_t'('0));
    Resetn = 1'b1;
    @(negedge Clock);
    checkOutput("rst_mid_after", observed(), ctl_t'('0));

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idleCycle();
      else applyStimulus(9'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
